auto_player: RTL and testbench

//  Computer opponent; the move-issuing end of the game controller's player interface.

---
 rtl/ttt_pkg.sv | 38 +++
 rtl/cell_threat.sv | 22 ++
 rtl/auto_player.sv | 195 +++++++++++++++++++
 tb/tb_auto_player.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and board helpers for the tic-tac-toe computer opponent.
package ttt_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b11,
        P2    = 2'b10
    } cell_t;

    typedef logic [3:0] addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE,
        ST_WAIT,
        ST_ERROR
    } state_t;

    localparam int NLINES = 8;

    localparam addr_t LINES [NLINES][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    // Addresses above 8 read as empty rather than indexing past the board.
    function automatic logic [1:0] cell_at(input logic [17:0] board, input addr_t i);
        logic [1:0] c;
        c = 2'b00;
        for (int k = 0; k < 9; k++) begin
            if (i == addr_t'(k)) c = board[2*k +: 2];
        end
        return c;
    endfunction

endpackage

// File: rtl/cell_threat.sv
// Combinational check: would placing `mark` at `idx` complete a line through idx.
module cell_threat
    import ttt_pkg::*;
(
    input  logic [17:0] gBoard,
    input  addr_t       idx,
    input  logic [1:0]  mark,
    output logic        completes
);

    always_comb begin
        completes = 1'b0;
        for (int l = 0; l < NLINES; l++) begin
            if ((LINES[l][0] == idx || LINES[l][1] == idx || LINES[l][2] == idx) &&
                (LINES[l][0] == idx || cell_at(gBoard, LINES[l][0]) == mark) &&
                (LINES[l][1] == idx || cell_at(gBoard, LINES[l][1]) == mark) &&
                (LINES[l][2] == idx || cell_at(gBoard, LINES[l][2]) == mark))
                completes = 1'b1;
        end
    end

endmodule

// File: rtl/auto_player.sv
// Computer opponent: detects its turn, scans the board for the best empty cell
// and issues a move strobe, retrying until its mark shows up on the board.
module auto_player
    import ttt_pkg::*;
#(
    parameter logic [1:0] MY_MARK   = 2'b10,
    parameter int         ACK_WAIT  = 8,
    parameter int         MAX_RETRY = 2
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        enable,
    input  logic        isPlayer1Start,
    input  logic [17:0] gBoard,
    input  logic        gameIsDone,
    output logic        playerWrite,
    output logic [3:0]  playerInput,
    output logic        busy,
    output logic        error
);

    localparam int TW = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [1:0] OPP = (MY_MARK == P1) ? P2 : P1;

    state_t          state, state_d;
    addr_t           idx, idx_d;
    logic [TW-1:0]   timer, timer_d;
    logic [RW-1:0]   retry, retry_d;
    logic            pw_q;
    addr_t           pin_q;
    logic            win_v, blk_v, cen_v, cor_v, sid_v;
    addr_t           win_a, blk_a, cor_a, sid_a;
    logic [17:0]     board_q;

    logic [3:0]      n1, n2;
    logic            any_empty;
    logic [1:0]      to_move;
    logic            my_turn;
    logic            abort;
    logic            clr, lat, issue_go;
    logic [1:0]      cur_cell, ack_cell;
    logic            cur_empty, is_corner;
    logic            me_win, opp_win;
    addr_t           sel;

    cell_threat u_win (.gBoard(gBoard), .idx(idx), .mark(MY_MARK), .completes(me_win));
    cell_threat u_blk (.gBoard(gBoard), .idx(idx), .mark(OPP),     .completes(opp_win));

    // Whose turn: equal counts means the starter moves, otherwise the other side.
    always_comb begin
        n1 = '0;
        n2 = '0;
        any_empty = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (gBoard[2*k +: 2] == P1) n1 = n1 + 4'd1;
            if (gBoard[2*k +: 2] == P2) n2 = n2 + 4'd1;
            if (gBoard[2*k +: 2] == EMPTY) any_empty = 1'b1;
        end
        if (n1 == n2) to_move = isPlayer1Start ? P1 : P2;
        else          to_move = isPlayer1Start ? P2 : P1;
        my_turn = (to_move == MY_MARK) && !gameIsDone && any_empty;
    end

    assign cur_cell  = cell_at(gBoard, idx);
    assign ack_cell  = cell_at(gBoard, pin_q);
    assign cur_empty = (cur_cell == EMPTY);
    assign is_corner = (idx == 4'd0) || (idx == 4'd2) || (idx == 4'd6) || (idx == 4'd8);
    // ERROR is left only through enable=0 or reset, so game-over does not clear it.
    assign abort     = !enable || (gameIsDone && state != ST_ERROR);

    always_comb begin
        sel = pin_q;
        if (win_v)      sel = win_a;
        else if (blk_v) sel = blk_a;
        else if (cen_v) sel = 4'd4;
        else if (cor_v) sel = cor_a;
        else if (sid_v) sel = sid_a;
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        timer_d  = timer;
        retry_d  = retry;
        clr      = 1'b0;
        lat      = 1'b0;
        issue_go = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (my_turn) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                        clr     = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (gBoard != board_q) begin
                        idx_d = '0;
                        clr   = 1'b1;
                    end else begin
                        lat = 1'b1;
                        if (idx == 4'd8) state_d = ST_ISSUE;
                        else             idx_d   = idx + 4'd1;
                    end
                end
                ST_ISSUE: begin
                    state_d  = ST_WAIT;
                    timer_d  = '0;
                    issue_go = 1'b1;
                end
                ST_WAIT: begin
                    if (ack_cell == MY_MARK) begin
                        state_d = ST_IDLE;
                        retry_d = '0;
                    end else if (ack_cell == OPP) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                        clr     = 1'b1;
                    end else if (timer == TW'(ACK_WAIT - 1)) begin
                        if (retry < RW'(MAX_RETRY)) begin
                            state_d = ST_ISSUE;
                            retry_d = retry + 1'b1;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end else begin
                        timer_d = timer + 1'b1;
                    end
                end
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            timer <= '0;
            retry <= '0;
            pw_q  <= 1'b0;
            pin_q <= '0;
            win_v <= 1'b0;
            blk_v <= 1'b0;
            cen_v <= 1'b0;
            cor_v <= 1'b0;
            sid_v <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            timer <= timer_d;
            retry <= retry_d;
            pw_q  <= issue_go;
            if (issue_go) pin_q <= sel;
            if (clr) begin
                win_v <= 1'b0;
                blk_v <= 1'b0;
                cen_v <= 1'b0;
                cor_v <= 1'b0;
                sid_v <= 1'b0;
            end else if (lat && cur_empty) begin
                if (me_win)               win_v <= 1'b1;
                if (opp_win)              blk_v <= 1'b1;
                if (idx == 4'd4)          cen_v <= 1'b1;
                if (is_corner)            cor_v <= 1'b1;
                if (!is_corner && idx != 4'd4) sid_v <= 1'b1;
            end
        end
    end

    // Candidate addresses only matter once their valid flag is set.
    always_ff @(posedge ph1) begin
        board_q <= gBoard;
        if (lat && cur_empty) begin
            if (me_win && !win_v)                        win_a <= idx;
            if (opp_win && !blk_v)                       blk_a <= idx;
            if (is_corner && !cor_v)                     cor_a <= idx;
            if (!is_corner && idx != 4'd4 && !sid_v)     sid_a <= idx;
        end
    end

    assign playerWrite = pw_q && enable && !gameIsDone;
    assign playerInput = pin_q;
    assign busy        = (state != ST_IDLE) && (state != ST_ERROR);
    assign error       = (state == ST_ERROR);

endmodule

// File: tb/tb_auto_player.sv
// Directed bench for auto_player: latency, move choice, retry/error and abort paths.
module tb_auto_player;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        enable;
    logic        isPlayer1Start;
    logic [17:0] gBoard;
    logic        gameIsDone;
    logic        playerWrite;
    logic [3:0]  playerInput;
    logic        busy;
    logic        error;

    int total = 0;
    int bad   = 0;
    int n, cnt;

    auto_player dut (
        .ph1(ph1), .reset(reset), .enable(enable), .isPlayer1Start(isPlayer1Start),
        .gBoard(gBoard), .gameIsDone(gameIsDone), .playerWrite(playerWrite),
        .playerInput(playerInput), .busy(busy), .error(error)
    );

    always #5 ph1 = ~ph1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    // Ticks until a strobe is seen; returns lim if none arrives.
    task automatic wait_pulse(input int lim, output int steps);
        steps = 0;
        while (steps < lim) begin
            tick();
            steps++;
            if (playerWrite) break;
        end
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (playerWrite) pulses++;
        end
    endtask

    function automatic logic [17:0] bd(input logic [8:0] p1, input logic [8:0] p2);
        logic [17:0] b;
        b = '0;
        for (int k = 0; k < 9; k++) begin
            if (p1[k])      b[2*k +: 2] = 2'b11;
            else if (p2[k]) b[2*k +: 2] = 2'b10;
        end
        return b;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        gameIsDone = 1'b0;
        isPlayer1Start = 1'b0;
        gBoard = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        reset = 1'b0;
        #1;
        chk("rst_write", playerWrite, 0);
        chk("rst_input", playerInput, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        reset = 1'b1;
        tick();

        // 1: empty board, we start -> center after 11 cycles, then acknowledged
        gBoard = bd(9'h000, 9'h000);
        enable = 1'b1;
        wait_pulse(40, n);
        chk("t1_latency", n, 11);
        chk("t1_addr", playerInput, 4);
        gBoard = bd(9'h000, 9'h010);
        tick();
        chk("t1_width", playerWrite, 0);
        chk("t1_ack_idle", busy, 0);
        count_pulses(15, cnt);
        chk("t1_no_more", cnt, 0);

        // 2: win at 2 beats block at 5
        do_reset();
        gBoard = bd(9'b000011000, 9'b000000011);
        enable = 1'b1;
        wait_pulse(40, n);
        chk("t2_latency", n, 11);
        chk("t2_addr", playerInput, 2);

        // 3: p1 started, center taken, no threats -> first corner 2
        do_reset();
        isPlayer1Start = 1'b1;
        gBoard = bd(9'b000010001, 9'b100000000);
        enable = 1'b1;
        wait_pulse(40, n);
        chk("t3_latency", n, 11);
        chk("t3_addr", playerInput, 2);

        // 5b: reset dropped mid-scan clears outputs without a clock edge
        enable = 1'b0;
        tick();
        isPlayer1Start = 1'b0;
        gBoard = bd(9'h000, 9'h000);
        enable = 1'b1;
        repeat (5) tick();
        chk("t5_scan_busy", busy, 1);
        chk("t5_hold_input", playerInput, 2);
        reset = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_input", playerInput, 0);
        chk("t5_rst_write", playerWrite, 0);

        // 4: never acknowledged -> three pulses ACK_WAIT+1 apart, then error
        do_reset();
        gBoard = bd(9'h000, 9'h000);
        enable = 1'b1;
        wait_pulse(40, n);
        chk("t4_first", n, 11);
        wait_pulse(40, n);
        chk("t4_retry1", n, 9);
        wait_pulse(40, n);
        chk("t4_retry2", n, 9);
        count_pulses(20, cnt);
        chk("t4_no_more", cnt, 0);
        chk("t4_error", error, 1);
        chk("t4_busy", busy, 0);
        chk("t4_hold_input", playerInput, 4);
        enable = 1'b0;
        tick();
        chk("t4_error_clr", error, 0);

        // 5a: game over during WAIT gates the strobe at once, then IDLE
        do_reset();
        gBoard = bd(9'h000, 9'h000);
        enable = 1'b1;
        wait_pulse(40, n);
        chk("t5_first", n, 11);
        gameIsDone = 1'b1;
        #1;
        chk("t5_gate", playerWrite, 0);
        tick();
        chk("t5_idle", busy, 0);
        count_pulses(15, cnt);
        chk("t5_no_more", cnt, 0);

        // 6: board changes at scan idx 5 -> pulse 6 cycles later than normal
        do_reset();
        gBoard = bd(9'h000, 9'h000);
        enable = 1'b1;
        repeat (6) tick();
        gBoard = bd(9'b000000001, 9'b100000000);
        wait_pulse(40, n);
        chk("t6_latency", n + 6, 17);
        chk("t6_addr", playerInput, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
